// File: rtl/register_dump_tx.sv
// Streams the register bank to the debug UART as one frame: a header byte,
// every register MSB first, and an XOR checksum over the data bytes.
module register_dump_tx #(
    parameter int unsigned NUM_REGS    = 32,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [32*NUM_REGS-1:0]   register_bank_in,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     dump_busy,
    output logic                     dump_done
);
    localparam int unsigned      REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK
    } state_t;

    state_t           state_q;
    logic [REG_W-1:0] regIdx_q;
    logic [1:0]       byteIdx_q;
    logic [7:0]       checksum_q;
    logic [31:0]      word_q;
    logic [7:0]       txData_q;
    logic             txValid_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic [REG_W-1:0] nextIdx;
    logic [31:0]      firstWord;
    logic [31:0]      nextWord;
    logic [7:0]       checksum_d;

    assign accept     = txValid_q & tx_ready;
    assign nextIdx    = regIdx_q + 1'b1;
    assign firstWord  = register_bank_in[31:0];
    assign nextWord   = register_bank_in[32*nextIdx +: 32];
    assign checksum_d = checksum_q ^ txData_q;

    // The word shift register keeps the bytes of the current register still to
    // be sent, so later bank changes cannot reach bytes already latched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            regIdx_q   <= '0;
            byteIdx_q  <= '0;
            checksum_q <= '0;
            word_q     <= '0;
            txData_q   <= '0;
            txValid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    regIdx_q  <= '0;
                    byteIdx_q <= '0;
                    if (start) begin
                        state_q    <= HEADER;
                        txData_q   <= HEADER_BYTE;
                        txValid_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        checksum_q <= '0;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        state_q   <= DATA;
                        word_q    <= firstWord;
                        txData_q  <= firstWord[31:24];
                        regIdx_q  <= '0;
                        byteIdx_q <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        checksum_q <= checksum_d;
                        if (byteIdx_q != 2'd3) begin
                            word_q    <= {word_q[23:0], 8'h00};
                            txData_q  <= word_q[23:16];
                            byteIdx_q <= byteIdx_q + 2'd1;
                        end else if (regIdx_q != LAST_REG) begin
                            regIdx_q  <= nextIdx;
                            word_q    <= nextWord;
                            txData_q  <= nextWord[31:24];
                            byteIdx_q <= '0;
                        end else begin
                            state_q  <= CHECK;
                            txData_q <= checksum_d;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        state_q   <= IDLE;
                        txData_q  <= '0;
                        txValid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        regIdx_q  <= '0;
                        byteIdx_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data   = txData_q;
    assign tx_valid  = txValid_q;
    assign dump_busy = busy_q;
    assign dump_done = done_q;

endmodule

// File: tb/tb_register_dump_tx.sv
// Directed bench for register_dump_tx: frames are compared byte by byte
// against a frame built from the bank the bench drives.
module tb_register_dump_tx;
    localparam int NUM_REGS  = 32;
    localparam int FRAME_LEN = 4*NUM_REGS + 2;

    localparam int M_NORMAL    = 0;
    localparam int M_START_MID = 1;
    localparam int M_REG_CHG   = 2;
    localparam int M_RESET     = 3;
    localparam int M_HELD      = 4;

    logic                   clock;
    logic                   reset_n;
    logic                   start;
    logic [32*NUM_REGS-1:0] register_bank_in;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   dump_busy;
    logic                   dump_done;

    logic [31:0] bankModel [NUM_REGS];
    logic [7:0]  expBytes  [FRAME_LEN];
    int          vectorCount = 0;
    int          missCount   = 0;

    register_dump_tx #(.NUM_REGS(NUM_REGS), .HEADER_BYTE(8'hA5)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .register_bank_in (register_bank_in),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .dump_busy        (dump_busy),
        .dump_done        (dump_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveBank();
        for (int i = 0; i < NUM_REGS; i++) register_bank_in[32*i +: 32] = bankModel[i];
    endtask

    // Frame reference: header, each register big-endian, XOR of data bytes.
    task automatic buildExpected();
        logic [7:0] cs;
        cs = 8'h00;
        expBytes[0] = 8'hA5;
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < 4; b++) begin
                expBytes[1 + 4*i + b] = bankModel[i][31 - 8*b -: 8];
                cs = cs ^ bankModel[i][31 - 8*b -: 8];
            end
        end
        expBytes[FRAME_LEN-1] = cs;
    endtask

    // Starts a frame on the next edge and consumes it; called at a negedge.
    task automatic applyStimulus(input int mode, input bit randomReady);
        int         idx;
        int         cycles;
        bit         stalled;
        bit         aborted;
        logic [7:0] held;
        idx = 0; cycles = 0; stalled = 0; aborted = 0; held = 8'h00;
        start = 1'b1;
        @(negedge clock);
        if (mode != M_HELD) start = 1'b0;
        while (idx < FRAME_LEN && cycles < 2000) begin
            if (mode == M_RESET && idx == 70) begin
                tx_ready = 1'b0;
                @(posedge clock);
                #2 reset_n = 1'b0;
                #1;
                checkOutput("rstValid", {31'd0, tx_valid}, 32'd0);
                checkOutput("rstBusy", {31'd0, dump_busy}, 32'd0);
                checkOutput("rstData", {24'd0, tx_data}, 32'd0);
                @(negedge clock);
                checkOutput("rstNoDone", {31'd0, dump_done}, 32'd0);
                reset_n = 1'b1;
                aborted = 1;
                break;
            end
            cycles++;
            checkOutput("validHigh", {31'd0, tx_valid}, 32'd1);
            if (stalled) checkOutput("stallHold", {24'd0, tx_data}, {24'd0, held});
            tx_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) begin
                checkOutput($sformatf("byte%0d", idx), {24'd0, tx_data}, {24'd0, expBytes[idx]});
                if (mode == M_START_MID && (idx == 3 || idx == 50 || idx == 129)) start = 1'b1;
                idx++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = tx_data;
            end
            @(negedge clock);
            if (mode != M_HELD) start = 1'b0;
            if (mode == M_REG_CHG && idx == 22) begin
                bankModel[5] = 32'hFFFFFFFF;
                driveBank();
            end
        end
        if (!aborted) begin
            if (idx < FRAME_LEN) checkOutput("timeout", idx, FRAME_LEN);
            if (!randomReady) checkOutput("frameCycles", cycles, FRAME_LEN);
            checkOutput("doneHigh", {31'd0, dump_done}, 32'd1);
            checkOutput("busyLow", {31'd0, dump_busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end of tests");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) bankModel[i] = 32'h0;
        driveBank();
        #2;
        checkOutput("resetData", {24'd0, tx_data}, 32'd0);
        checkOutput("resetValid", {31'd0, tx_valid}, 32'd0);
        checkOutput("resetBusy", {31'd0, dump_busy}, 32'd0);
        checkOutput("resetDone", {31'd0, dump_done}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("idleValid", {31'd0, tx_valid}, 32'd0);

        $display("[TB] incrementing bank, ready held high");
        for (int i = 0; i < NUM_REGS; i++) bankModel[i] = 32'(i + 1);
        driveBank();
        buildExpected();
        checkOutput("incChecksum", {24'd0, expBytes[FRAME_LEN-1]}, 32'h20);
        applyStimulus(M_NORMAL, 1'b0);

        $display("[TB] DEAD0000 bank, random ready");
        for (int i = 0; i < NUM_REGS; i++) bankModel[i] = 32'hDEAD0000 + 32'(i);
        driveBank();
        buildExpected();
        applyStimulus(M_NORMAL, 1'b1);
        @(negedge clock);

        $display("[TB] start pulses during a frame");
        applyStimulus(M_START_MID, 1'b0);
        @(negedge clock);
        checkOutput("noSecondValid", {31'd0, tx_valid}, 32'd0);
        checkOutput("noSecondBusy", {31'd0, dump_busy}, 32'd0);
        checkOutput("singleDone", {31'd0, dump_done}, 32'd0);

        $display("[TB] register 5 changed after its first byte");
        bankModel[5] = 32'h11223344;
        driveBank();
        buildExpected();
        applyStimulus(M_REG_CHG, 1'b0);
        @(negedge clock);

        $display("[TB] reset during a stalled frame");
        for (int i = 0; i < NUM_REGS; i++) bankModel[i] = 32'hDEAD0000 + 32'(i);
        driveBank();
        buildExpected();
        applyStimulus(M_RESET, 1'b0);
        @(negedge clock);
        checkOutput("postRstIdle", {31'd0, tx_valid}, 32'd0);
        applyStimulus(M_NORMAL, 1'b0);
        @(negedge clock);

        $display("[TB] start held high, back-to-back frames");
        applyStimulus(M_HELD, 1'b0);
        applyStimulus(M_HELD, 1'b0);
        start = 1'b0;
        @(negedge clock);
        checkOutput("heldStopValid", {31'd0, tx_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
